// File: rtl/universal_shift_register.sv
// Universal shift register: logical/rotate/arithmetic shifts, parallel load,
// synchronous clear, clock enable, registered serial output and a shift
// counter that emits a one-cycle frame_done pulse every WIDTH shifts.
module universal_shift_register #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int              CNT_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic [CNT_W-1:0] shift_count,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ASR   = 3'b101,
        MODE_LOAD  = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_t;

    // Count value at which the next shift completes a frame.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mode_t            op;
    logic [WIDTH-1:0] next_out;
    logic             next_ser;
    logic             is_shift;  // op advances the frame counter
    logic             restart;   // op discards the frame in progress

    assign op = mode_t'(mode);

    // Decode the selected operation into next register/serial values.
    always_comb begin
        next_out = out;
        next_ser = ser_out;
        is_shift = 1'b0;
        restart  = 1'b0;
        case (op)
            MODE_HOLD: ;
            MODE_SHL: begin
                next_out = {out[WIDTH-2:0], shift_in};
                next_ser = out[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                next_out = {shift_in, out[WIDTH-1:1]};
                next_ser = out[0];
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                next_out = {out[WIDTH-2:0], out[WIDTH-1]};
                next_ser = out[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                next_out = {out[0], out[WIDTH-1:1]};
                next_ser = out[0];
                is_shift = 1'b1;
            end
            MODE_ASR: begin
                next_out = {out[WIDTH-1], out[WIDTH-1:1]};
                next_ser = out[0];
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                next_out = par_in;
                next_ser = 1'b0;
                restart  = 1'b1;
            end
            MODE_CLEAR: begin
                next_out = RESET_VALUE;
                next_ser = 1'b0;
                restart  = 1'b1;
            end
            default: ;
        endcase
    end

    // Data register and serial output; both freeze while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= RESET_VALUE;
            ser_out <= 1'b0;
        end else if (en) begin
            out     <= next_out;
            ser_out <= next_ser;
        end
    end

    // Frame counter; frame_done is high only after a wrapping shift edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                if (restart) begin
                    shift_count <= '0;
                end else if (is_shift) begin
                    if (shift_count == LAST) begin
                        shift_count <= '0;
                        frame_done  <= 1'b1;
                    end else begin
                        shift_count <= shift_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: an 8-bit default instance and
// a 5-bit instance with a non-zero reset value, checked against hand values.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    // 8-bit instance
    logic       en;
    logic [2:0] mode;
    logic       shift_in;
    logic [7:0] par_in;
    logic [7:0] out;
    logic       ser_out;
    logic [2:0] shift_count;
    logic       frame_done;
    // 5-bit instance
    logic       en5;
    logic [2:0] mode5;
    logic       shift_in5;
    logic [4:0] par_in5;
    logic [4:0] out5;
    logic       ser_out5;
    logic [2:0] shift_count5;
    logic       frame_done5;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [2:0] HOLD = 3'b000, SHL = 3'b001, SHR = 3'b010,
                           ROL = 3'b011, ROR = 3'b100, ASR = 3'b101,
                           LOAD = 3'b110, CLR = 3'b111;

    universal_shift_register #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .shift_in(shift_in),
        .par_in(par_in), .out(out), .ser_out(ser_out),
        .shift_count(shift_count), .frame_done(frame_done)
    );

    universal_shift_register #(.WIDTH(5), .RESET_VALUE(5'b10101)) dut5 (
        .clk(clk), .rst(rst), .en(en5), .mode(mode5), .shift_in(shift_in5),
        .par_in(par_in5), .out(out5), .ser_out(ser_out5),
        .shift_count(shift_count5), .frame_done(frame_done5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic si, input logic [7:0] p);
        en = 1'b1; mode = m; shift_in = si; par_in = p;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq;
        rst = 1'b1; en = 1'b0; mode = HOLD; shift_in = 1'b0; par_in = '0;
        en5 = 1'b0; mode5 = HOLD; shift_in5 = 1'b0; par_in5 = '0;
        step(); step();
        check("rst_out", 32'(out), 32'h00);
        check("rst_out5", 32'(out5), 32'h15);
        rst = 1'b0;

        // 1. async reset between edges
        op(LOAD, 1'b0, 8'h5A);
        check("load_5a", 32'(out), 32'h5A);
        op(SHL, 1'b1, 8'h00);
        check("pre_rst_cnt", 32'(shift_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'h00);
        check("arst_ser", 32'(ser_out), 32'd0);
        check("arst_cnt", 32'(shift_count), 32'd0);
        check("arst_fd", 32'(frame_done), 32'd0);
        step(); step();
        check("rst_hold_out", 32'(out), 32'h00);
        check("rst_hold_cnt", 32'(shift_count), 32'd0);
        rst = 1'b0;

        // 2. SIPO frame: 1,0,1,1,0,0,1,0 -> 8'hB2
        seq = 8'b10110010;
        for (int i = 0; i < 8; i++) begin
            op(SHL, seq[7-i], 8'h00);
            check("sipo_cnt", 32'(shift_count), 32'((i + 1) % 8));
            check("sipo_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("sipo_out", 32'(out), 32'hB2);
        for (int i = 0; i < 8; i++) begin
            op(SHL, 1'b0, 8'h00);
            check("sipo2_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("sipo2_out", 32'(out), 32'h00);
        check("sipo2_ser", 32'(ser_out), 32'd0);

        // 3. rotates
        op(LOAD, 1'b0, 8'h81);
        check("load_ser", 32'(ser_out), 32'd0);
        op(ROL, 1'b0, 8'h00);
        check("rol_out", 32'(out), 32'h03);
        check("rol_ser", 32'(ser_out), 32'd1);
        op(LOAD, 1'b0, 8'h81);
        op(ROR, 1'b0, 8'h00);
        check("ror_out", 32'(out), 32'hC0);
        check("ror_ser", 32'(ser_out), 32'd1);
        op(LOAD, 1'b0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            op(ROL, 1'b0, 8'h00);
            check("rol8_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("rol8_out", 32'(out), 32'h81);

        // 4. right shifts
        op(LOAD, 1'b0, 8'h80);
        op(ASR, 1'b0, 8'h00);
        check("asr1_out", 32'(out), 32'hC0);
        op(ASR, 1'b0, 8'h00);
        op(ASR, 1'b0, 8'h00);
        check("asr3_out", 32'(out), 32'hF0);
        check("asr3_ser", 32'(ser_out), 32'd0);
        check("asr3_cnt", 32'(shift_count), 32'd3);
        op(LOAD, 1'b0, 8'h80);
        op(SHR, 1'b0, 8'h00);
        check("shr0_out", 32'(out), 32'h40);
        op(LOAD, 1'b0, 8'h01);
        op(SHR, 1'b1, 8'h00);
        check("shr1_out", 32'(out), 32'h80);
        check("shr1_ser", 32'(ser_out), 32'd1);

        // 5. enable, hold and restart
        op(LOAD, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) op(SHL, 1'b1, 8'h00);
        check("en_pre_out", 32'(out), 32'h1F);
        check("en_pre_cnt", 32'(shift_count), 32'd5);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; mode = SHL; shift_in = 1'b1;
            step();
            check("en0_out", 32'(out), 32'h1F);
            check("en0_cnt", 32'(shift_count), 32'd5);
            check("en0_fd", 32'(frame_done), 32'd0);
        end
        op(HOLD, 1'b1, 8'h00);
        check("hold_out", 32'(out), 32'h1F);
        check("hold_cnt", 32'(shift_count), 32'd5);
        op(LOAD, 1'b0, 8'hFF);
        check("reload_cnt", 32'(shift_count), 32'd0);
        check("reload_out", 32'(out), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            op(SHL, 1'b0, 8'h00);
            check("restart_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        // load on what would have been the wrapping edge: no pulse
        for (int i = 0; i < 7; i++) op(SHL, 1'b0, 8'h00);
        check("prewrap_cnt", 32'(shift_count), 32'd7);
        op(LOAD, 1'b0, 8'h3C);
        check("wrapload_fd", 32'(frame_done), 32'd0);
        check("wrapload_cnt", 32'(shift_count), 32'd0);
        en = 1'b0; mode = HOLD;

        // 6. WIDTH=5, RESET_VALUE=5'b10101
        rst = 1'b1;
        #3;
        check("w5_rst_out", 32'(out5), 32'h15);
        step();
        rst = 1'b0;
        en5 = 1'b1; mode5 = SHL; shift_in5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("w5_fd", 32'(frame_done5), (i == 4) ? 32'd1 : 32'd0);
        end
        check("w5_out", 32'(out5), 32'h00);
        check("w5_cnt", 32'(shift_count5), 32'd0);
        mode5 = SHL;
        step();
        check("w5_cnt1", 32'(shift_count5), 32'd1);
        mode5 = CLR;
        step();
        check("w5_clr_out", 32'(out5), 32'h15);
        check("w5_clr_cnt", 32'(shift_count5), 32'd0);
        check("w5_clr_fd", 32'(frame_done5), 32'd0);
        en5 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised universal shift register. It generalises the team's fixed 8-bit left-shift SIPO register with the following additions:
- configurable width
- left/right logical, rotate and arithmetic shifts
- parallel load and synchronous clear
- clock enable
- registered serial output
- shift counter with a frame-complete pulse

It serves as the SIPO/PISO building block for the serial link and test datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out by reset and by the clear mode.
- CNT_W, $clog2(WIDTH), width of shift_count; derived, not overridden.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- en, input, 1, operation enable; when low, all state holds.
- mode, input, 3, operation select (encoding under Behaviour).
- shift_in, input, 1, serial fill bit for the logical shift modes.
- par_in, input, WIDTH, parallel load data.
- out, output, WIDTH, register contents (registered).
- ser_out, output, 1, last bit shifted out of the register (registered).
- shift_count, output, CNT_W, number of shifts since the last load, clear or wrap (registered).
- frame_done, output, 1, one-cycle pulse marking completion of WIDTH shifts (registered).

Behaviour:
- Reset (rst=1): takes effect immediately, independent of clk. Values while rst is held:
  - out = RESET_VALUE
  - ser_out = 0
  - shift_count = 0
  - frame_done = 0
- Release of rst: the first active edge is the first clk rising edge with rst=0.
- Reset mid-operation: the frame in progress is discarded; there is no partial frame_done.
- en=0:
  - out, ser_out and shift_count hold, regardless of mode.
  - frame_done = 0 at that edge.
- mode encoding, applied at the clk edge when en=1 (o = out before the edge, W = WIDTH):
  - 000 hold: out, ser_out and shift_count unchanged.
  - 001 SHL: out = {o[W-2:0], shift_in}; ser_out = o[W-1].
  - 010 SHR: out = {shift_in, o[W-1:1]}; ser_out = o[0].
  - 011 ROL: out = {o[W-2:0], o[W-1]}; ser_out = o[W-1].
  - 100 ROR: out = {o[0], o[W-1:1]}; ser_out = o[0].
  - 101 ASR: out = {o[W-1], o[W-1:1]}; ser_out = o[0].
  - 110 LOAD: out = par_in; ser_out = 0; shift_count = 0.
  - 111 CLEAR: out = RESET_VALUE; ser_out = 0; shift_count = 0.
- Latency: one cycle for every mode; all outputs are registered, with no combinational input-to-output path.
- Counting:
  - Modes 001-101 are shift modes; each shift with en=1 increments shift_count.
  - If shift_count == W-1 at a shift edge:
    - shift_count wraps to 0 at that edge;
    - frame_done = 1 for exactly the following cycle.
- frame_done is 0 after any edge that is not a wrapping shift. This includes:
  - hold, load and clear edges;
  - edges with en=0.
- Mixing shift kinds within a frame is legal; all shift modes count identically.
- Load or clear at the wrapping edge: no pulse, because load/clear is not a shift.
- Back-to-back frames: continuous shifting gives a frame_done pulse every W cycles with no gap cycle.
- Unknown or X on mode is not supported; the bench shall not drive it.

Test Plan:
1. Async reset: WIDTH=8, load 8'h5A, then assert rst between clk edges -> out=8'h00, ser_out=0, shift_count=0 before the next edge. Hold rst across 2 edges -> values unchanged.
2. SIPO frame: after reset, mode=001, en=1, shift_in sequence 1,0,1,1,0,0,1,0 on 8 edges -> out=8'hB2.
   - shift_count reads 1..7, then 0.
   - frame_done=1 only in the cycle after edge 8.
   - Continue 8 more shifts -> second pulse exactly 8 cycles later.
3. Rotates: load 8'h81, ROL -> out=8'h03, ser_out=1. Load 8'h81, ROR -> out=8'hC0, ser_out=1. Load 8'h81, 8 ROLs -> out=8'h81 with frame_done pulse.
4. Right shifts:
   - Load 8'h80, ASR x3 -> out=8'hF0, ser_out=0.
   - Load 8'h80, SHR with shift_in=0 -> out=8'h40.
   - Load 8'h01, SHR with shift_in=1 -> out=8'h80, ser_out=1.
5. Enable and restart:
   - 5 SHL shifts, then en=0 for 3 cycles with mode=001 -> out and shift_count=5 held, frame_done=0.
   - Then LOAD 8'hFF -> shift_count=0.
   - frame_done first appears only after 8 further shifts, not 3.
6. WIDTH=5, RESET_VALUE=5'b10101 instance:
   - Reset -> out=5'h15.
   - 5 SHL with shift_in=0 -> out=5'h00, frame_done pulses after edge 5.
   - CLEAR -> out=5'h15, shift_count=0.
